mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM/IO port and shares it between the instruction fetcher (IF, 32-bit reads) and the load/store buffer (LSB, 1/2/4-byte loads and stores).
- Arbitrates between the two requesters, sequences each access as consecutive single-byte RAM cycles, assembles or splits little-endian words, and returns a one-cycle done pulse to the winner.
- Sits between the IF/LSB units and the top-level memory pins.

Parameters:
- ADDR_W, 32, address width for requester and RAM addresses.
- IO_BASE, 32'h0003_0000, addresses at or above this value are IO; IO stores are subject to io_buffer_full.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global ready; low = pause
- _clear  in  1  mispredict flush
- if_req  in  1  IF read request, level
- if_addr  in  32  IF word address
- if_done  out  1  IF access complete, 1-cycle pulse
- if_data  out  32  fetched word
- lsb_req  in  1  LSB request, level
- lsb_r_nw  in  1  1 = load, 0 = store
- lsb_addr  in  32  LSB byte address
- lsb_size  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
- lsb_wdata  in  32  store data, low bytes used
- lsb_done  out  1  LSB access complete, 1-cycle pulse
- lsb_rdata  out  32  load data, zero-extended
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write this cycle
- io_buffer_full  in  1  UART TX buffer full

Behaviour:
- Clock and reset
  - Single clock clk_in.
  - rst_in is synchronous, active-low, and sampled at the rising edge.
  - Reset dominates rdy_in and _clear.
- Reset state
  - State IDLE.
  - if_done, lsb_done, mem_wr = 0; mem_a, mem_dout, if_data, lsb_rdata = 0.
  - last_grant = IF, so the LSB wins the first tie.
- States: IDLE, READ, WRITE.
  - Byte counter k ranges 0..N-1, where N = 1, 2 or 4. IF reads always use N = 4.
- Arbitration (IDLE only)
  - Only LSB requesting → grant LSB.
  - Only IF requesting → grant IF.
  - Both requesting → grant the one that is not last_grant.
  - last_grant updates on each grant.
- Request masking
  - In the cycle a requester's done is high, its req is ignored. The requester deasserts req or presents a new request from the next cycle.
  - While _clear is high, no grant is made.
- Read timing
  - Request sampled at edge E0.
  - In cycle i (i = 1..N, after E0): mem_a = base + i - 1, mem_wr = 0.
  - mem_din holds byte i-1 in cycle i+1 (RAM latency is 1).
  - Byte j lands in bits [8j+7:8j]; unused upper bytes are 0.
  - The final byte is captured at the end of cycle N+1. The done pulse and data are registered and visible in cycle N+2.
  - From cycle N+1, mem_a = 0 and mem_wr = 0 until the next grant.
  - Word read: done in cycle 6. Byte read: done in cycle 3.
- Write timing
  - In cycle i (i = 1..N): mem_wr = 1, mem_a = base + i - 1, mem_dout = lsb_wdata byte i-1.
  - lsb_done is visible in cycle N+1.
  - If addr >= IO_BASE and io_buffer_full = 1 at the edge that would issue a byte, that byte is held: mem_wr = 0 and the counter is frozen until io_buffer_full = 0.
- Outputs between accesses
  - if_data and lsb_rdata hold their last value.
  - mem_dout = 0 whenever mem_wr = 0.
- Address arithmetic
  - base + k wraps modulo 2^32.
  - No alignment check is performed; misaligned accesses are split byte-wise.
- _clear (sampled at edge)
  - READ (IF or load): abort, return to IDLE, no done pulse, mem_a = 0 next cycle; in-flight mem_din is discarded.
  - WRITE: stores are committed, so the write continues to completion and lsb_done still pulses.
  - A done pulse already registered remains visible.
- rdy_in = 0
  - All registers hold and mem_wr is forced to 0.
  - The sequence resumes at the same byte when rdy_in returns to 1.
  - Done pulses are not repeated.
- Reset mid-access
  - Immediate return to IDLE.
  - Partial stores are not completed.
  - No done pulse is produced.
- Concurrency
  - At most one access is in flight.
  - if_done and lsb_done are never high in the same cycle.

Test Plan:
- Reset, then if_req = 1 with if_addr = 0x100 and RAM bytes 0x13, 0x05, 0x00, 0x00 → mem_a = 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_data = 0x00000513.
- lsb_req store, size 1, addr 0x2002, wdata 0xAABBCCDD → cycles 1-2: mem_wr = 1, mem_a = 0x2002/0x2003, mem_dout = 0xDD/0xCC; lsb_done in cycle 3.
- if_req and lsb_req both raised from reset → LSB granted first, then IF; with both still requesting, grants alternate LSB, IF, LSB.
- IF word read with _clear high at the edge ending cycle 2 → no if_done; mem_a = 0 from cycle 3; a following LSB byte load completes normally.
- Word store to 0x30000 with io_buffer_full high for cycles 2-4 → byte 0 is written, bytes 1-3 are delayed by 3 cycles, and lsb_done still follows the last write.
- rst_in low during a word load at cycle 3 → next cycle: all outputs 0 and state IDLE; the subsequent IF read completes with 6-cycle latency.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-pin bundle for mem_arbiter
//
// Purpose: groups the IF fetch port, the LSB load/store port and the
// byte-wide RAM/IO pins that mem_arbiter owns.
// Ports (signals):
//   if_req/if_addr -> if_done/if_data          IF word fetch
//   lsb_req/lsb_r_nw/lsb_addr/lsb_size/lsb_wdata -> lsb_done/lsb_rdata
//   mem_din, io_buffer_full -> mem_dout/mem_a/mem_wr   RAM/IO pins
// Modports: slave = the arbiter, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  logic              lsb_req;
  logic              lsb_r_nw;
  logic [ADDR_W-1:0] lsb_addr;
  logic [1:0]        lsb_size;
  logic [31:0]       lsb_wdata;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;

  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              io_buffer_full;

  modport slave (
    input  if_req, if_addr,
    output if_done, if_data,
    input  lsb_req, lsb_r_nw, lsb_addr, lsb_size, lsb_wdata,
    output lsb_done, lsb_rdata,
    input  mem_din, io_buffer_full,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr,
    input  if_done, if_data,
    output lsb_req, lsb_r_nw, lsb_addr, lsb_size, lsb_wdata,
    input  lsb_done, lsb_rdata,
    output mem_din, io_buffer_full,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares the byte-wide RAM/IO port between IF and LSB
//
// Purpose: arbitrates IF fetches and LSB loads/stores onto one byte-wide
// RAM port, sequencing each access as consecutive byte cycles and packing
// or splitting little-endian words. The winner gets a one-cycle done pulse.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-low reset
//   rdy_in  - global ready, low pauses everything
//   _clear  - mispredict flush (aborts reads, blocks new grants)
//   bus     - mem_arbiter_if.slave: IF port, LSB port, RAM/IO pins
module mem_arbiter #(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = 'h0003_0000
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         _clear,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;
  typedef enum logic {G_IF = 1'b0, G_LSB = 1'b1} grant_t;

  state_t            state_q, state_d;
  grant_t            last_grant_q, last_grant_d;
  // Reads: k = cycle index since grant minus one (0..N). Writes: bytes issued.
  logic [2:0]        k_q, k_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              to_if_q, to_if_d;
  logic              io_q, io_d;
  logic [31:0]       acc_q, acc_d;

  logic [ADDR_W-1:0] mem_a_q, mem_a_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              lsb_done_q, lsb_done_d;
  logic [31:0]       lsb_rdata_q, lsb_rdata_d;

  logic              if_go, lsb_go, pick_lsb, lsb_io, wr_blocked;
  logic [2:0]        lsb_n;
  logic [1:0]        cap_idx, wr_idx;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      last_grant_q <= G_IF;
      k_q          <= '0;
      n_q          <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      to_if_q      <= 1'b0;
      io_q         <= 1'b0;
      acc_q        <= '0;
      mem_a_q      <= '0;
      mem_wr_q     <= 1'b0;
      mem_dout_q   <= '0;
      if_done_q    <= 1'b0;
      if_data_q    <= '0;
      lsb_done_q   <= 1'b0;
      lsb_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      k_q          <= k_d;
      n_q          <= n_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      to_if_q      <= to_if_d;
      io_q         <= io_d;
      acc_q        <= acc_d;
      mem_a_q      <= mem_a_d;
      mem_wr_q     <= mem_wr_d;
      mem_dout_q   <= mem_dout_d;
      if_done_q    <= if_done_d;
      if_data_q    <= if_data_d;
      lsb_done_q   <= lsb_done_d;
      lsb_rdata_q  <= lsb_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    k_d          = k_q;
    n_d          = n_q;
    base_d       = base_q;
    wdata_d      = wdata_q;
    to_if_d      = to_if_q;
    io_d         = io_q;
    acc_d        = acc_q;
    mem_a_d      = mem_a_q;
    mem_wr_d     = mem_wr_q;
    mem_dout_d   = mem_dout_q;
    if_data_d    = if_data_q;
    lsb_rdata_d  = lsb_rdata_q;
    // Done is a pulse: dropped on any edge, including paused ones.
    if_done_d    = 1'b0;
    lsb_done_d   = 1'b0;

    // A requester's req is ignored in the cycle its done is showing.
    if_go      = bus.if_req && !if_done_q;
    lsb_go     = bus.lsb_req && !lsb_done_q;
    pick_lsb   = lsb_go && (!if_go || last_grant_q == G_IF);
    lsb_io     = bus.lsb_addr >= IO_BASE;
    wr_blocked = io_q && bus.io_buffer_full;
    // Byte arriving on mem_din belongs to the address issued one cycle earlier.
    cap_idx    = k_q[1:0] - 2'd1;
    wr_idx     = k_q[1:0];
    case (bus.lsb_size)
      2'd0:    lsb_n = 3'd1;
      2'd1:    lsb_n = 3'd2;
      default: lsb_n = 3'd4;
    endcase

    if (rdy_in) begin
      mem_wr_d   = 1'b0;
      mem_dout_d = 8'd0;
      unique case (state_q)
        S_IDLE: begin
          mem_a_d = '0;
          if (!_clear && (if_go || lsb_go)) begin
            k_d   = 3'd0;
            acc_d = '0;
            if (pick_lsb) begin
              last_grant_d = G_LSB;
              to_if_d      = 1'b0;
              base_d       = bus.lsb_addr;
              n_d          = lsb_n;
              wdata_d      = bus.lsb_wdata;
              io_d         = lsb_io;
              if (bus.lsb_r_nw) begin
                state_d = S_READ;
                mem_a_d = bus.lsb_addr;
              end else begin
                state_d = S_WRITE;
                // First byte issues on the grant edge unless IO is back-pressured.
                if (!(lsb_io && bus.io_buffer_full)) begin
                  mem_wr_d   = 1'b1;
                  mem_a_d    = bus.lsb_addr;
                  mem_dout_d = bus.lsb_wdata[7:0];
                  k_d        = 3'd1;
                end
              end
            end else begin
              last_grant_d = G_IF;
              to_if_d      = 1'b1;
              base_d       = bus.if_addr;
              n_d          = 3'd4;
              io_d         = 1'b0;
              state_d      = S_READ;
              mem_a_d      = bus.if_addr;
            end
          end
        end

        S_READ: begin
          if (_clear) begin
            state_d = S_IDLE;
            mem_a_d = '0;
          end else begin
            if (k_q != 3'd0) begin
              acc_d[8*cap_idx +: 8] = bus.mem_din;
            end
            mem_a_d = (k_q + 3'd1 < n_q) ? base_q + ADDR_W'(k_q) + ADDR_W'(1) : '0;
            if (k_q == n_q) begin
              state_d = S_IDLE;
              if (to_if_q) begin
                if_done_d = 1'b1;
                if_data_d = acc_d;
              end else begin
                lsb_done_d  = 1'b1;
                lsb_rdata_d = acc_d;
              end
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end

        S_WRITE: begin
          // Stores are committed: _clear does not stop them.
          mem_a_d = '0;
          if (k_q == n_q) begin
            lsb_done_d = 1'b1;
            state_d    = S_IDLE;
          end else if (!wr_blocked) begin
            mem_wr_d   = 1'b1;
            mem_a_d    = base_q + ADDR_W'(k_q);
            mem_dout_d = wdata_q[8*wr_idx +: 8];
            k_d        = k_q + 3'd1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.mem_a     = mem_a_q;
  assign bus.mem_wr    = mem_wr_q && rdy_in;
  assign bus.mem_dout  = (mem_wr_q && rdy_in) ? mem_dout_q : 8'd0;
  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clr;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h0003_0000)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    ._clear (clr),
    .bus    (bus)
  );

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102, 32'h103: return 8'h00;
      default: return a[7:0] * 8'd7 + a[15:8] + 8'h5b;
    endcase
  endfunction

  always @(posedge clk_in) bus.mem_din <= rom(bus.mem_a);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Transaction-level model: an access is a base, a byte count and a kind;
  // read bus activity follows from the cycle offset since grant, writes
  // from the number of bytes already issued.
  bit          m_valid = 1'b0, m_busy = 1'b0, m_last_lsb = 1'b0, m_io;
  int          m_kind, m_n, m_t, m_issued;
  logic [31:0] m_base, m_wdata, m_data;
  logic [31:0] e_a, e_ifdata, e_lsbdata;
  logic [7:0]  e_dout;
  bit          e_wr, e_ifd, e_lsbd;

  task automatic write_step();
    e_a = 32'd0; e_wr = 1'b0; e_dout = 8'd0;
    if (m_issued == m_n) begin
      e_lsbd = 1'b1;
      m_busy = 1'b0;
    end else if (!(m_io && bus.io_buffer_full)) begin
      e_wr   = 1'b1;
      e_a    = m_base + 32'(m_issued);
      e_dout = 8'(m_wdata >> (8 * m_issued));
      m_issued++;
    end
  endtask

  task automatic model_edge();
    bit ifd_now, lsbd_now, was_busy, ifr, lr;
    if (!rst_in) begin
      m_valid = 1'b1; m_busy = 1'b0; m_last_lsb = 1'b0;
      e_a = '0; e_wr = 1'b0; e_dout = '0; e_ifd = 1'b0; e_lsbd = 1'b0;
      e_ifdata = '0; e_lsbdata = '0;
    end else if (m_valid && !rdy_in) begin
      e_ifd = 1'b0; e_lsbd = 1'b0;
    end else if (m_valid) begin
      ifd_now = e_ifd; lsbd_now = e_lsbd;
      e_ifd = 1'b0; e_lsbd = 1'b0;
      was_busy = m_busy;
      if (m_busy && m_kind != 2) begin
        e_wr = 1'b0; e_dout = 8'd0;
        if (clr) begin
          m_busy = 1'b0; e_a = 32'd0;
        end else begin
          m_t++;
          e_a = (m_t <= m_n) ? m_base + 32'(m_t - 1) : 32'd0;
          if (m_t == m_n + 2) begin
            m_busy = 1'b0;
            if (m_kind == 0) begin e_ifd = 1'b1; e_ifdata = m_data; end
            else begin e_lsbd = 1'b1; e_lsbdata = m_data; end
          end
        end
      end else if (m_busy) begin
        write_step();
      end
      if (!was_busy) begin
        e_a = 32'd0; e_wr = 1'b0; e_dout = 8'd0;
        ifr = bus.if_req && !ifd_now;
        lr  = bus.lsb_req && !lsbd_now;
        if (!clr && (ifr || lr)) begin
          if (lr && (!ifr || !m_last_lsb)) begin
            m_kind = bus.lsb_r_nw ? 1 : 2;
            m_base = bus.lsb_addr; m_wdata = bus.lsb_wdata;
            m_n = (bus.lsb_size == 2'd0) ? 1 : (bus.lsb_size == 2'd1) ? 2 : 4;
            m_io = bus.lsb_addr >= 32'h0003_0000;
            m_last_lsb = 1'b1;
          end else begin
            m_kind = 0; m_base = bus.if_addr; m_n = 4; m_io = 1'b0;
            m_last_lsb = 1'b0;
          end
          m_data = 32'd0;
          for (int j = 0; j < m_n; j++) m_data = m_data | (32'(rom(m_base + 32'(j))) << (8 * j));
          m_busy = 1'b1;
          if (m_kind != 2) begin m_t = 1; e_a = m_base; end
          else begin m_issued = 0; write_step(); end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
    model_edge();
  end

  initial forever begin
    @(negedge clk_in);
    if (m_valid) begin
      chk("mem_a", bus.mem_a, e_a);
      chk("mem_wr", 32'(bus.mem_wr), 32'(e_wr && rdy_in));
      chk("mem_dout", 32'(bus.mem_dout), (e_wr && rdy_in) ? 32'(e_dout) : 32'd0);
      chk("if_done", 32'(bus.if_done), 32'(e_ifd));
      chk("lsb_done", 32'(bus.lsb_done), 32'(e_lsbd));
      chk("if_data", bus.if_data, e_ifdata);
      chk("lsb_rdata", bus.lsb_rdata, e_lsbdata);
      chk("both_done", 32'(bus.if_done && bus.lsb_done), 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #3;
  endtask

  task automatic lsb_set(input bit rnw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.lsb_req = 1'b1; bus.lsb_r_nw = rnw; bus.lsb_size = sz;
    bus.lsb_addr = a; bus.lsb_wdata = wd;
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; clr = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.lsb_req = 1'b0; bus.lsb_r_nw = 1'b1; bus.lsb_addr = '0;
    bus.lsb_size = '0; bus.lsb_wdata = '0; bus.io_buffer_full = 1'b0;
    step(2);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);

    // IF word fetch at 0x100
    rst_in = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step(1); chk("f_a1", bus.mem_a, 32'h100);
    step(3); chk("f_a4", bus.mem_a, 32'h103);
    step(1); chk("f_a5", bus.mem_a, 32'h0);
    step(1); chk("f_done", 32'(bus.if_done), 32'd1);
    chk("f_data", bus.if_data, 32'h0000_0513);
    chk("f_model", e_ifdata, 32'h0000_0513);
    bus.if_req = 1'b0;

    // half store at 0x2002
    lsb_set(1'b0, 2'd1, 32'h2002, 32'hAABBCCDD);
    step(1); chk("s_wr1", 32'(bus.mem_wr), 32'd1);
    chk("s_a1", bus.mem_a, 32'h2002); chk("s_d1", 32'(bus.mem_dout), 32'hDD);
    step(1); chk("s_a2", bus.mem_a, 32'h2003); chk("s_d2", 32'(bus.mem_dout), 32'hCC);
    step(1); chk("s_done", 32'(bus.lsb_done), 32'd1);
    bus.lsb_req = 1'b0;

    // both requesting from reset: LSB, IF, LSB
    rst_in = 1'b0; step(1);
    rst_in = 1'b1; bus.if_req = 1'b1; bus.if_addr = 32'h100;
    lsb_set(1'b1, 2'd0, 32'h10, 32'h0);
    step(3); chk("a_lsb1", 32'(bus.lsb_done), 32'd1);
    chk("a_rdata", bus.lsb_rdata, 32'h0000_00CB);
    step(6); chk("a_if", 32'(bus.if_done), 32'd1);
    step(3); chk("a_lsb2", 32'(bus.lsb_done), 32'd1);
    bus.if_req = 1'b0; bus.lsb_req = 1'b0;
    step(1);

    // flush aborts an IF read; a byte load follows
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    step(2); clr = 1'b1; bus.if_req = 1'b0;
    step(1); chk("c_a3", bus.mem_a, 32'h0);
    clr = 1'b0; lsb_set(1'b1, 2'd0, 32'h300, 32'h0);
    step(1); chk("c_a4", bus.mem_a, 32'h300);
    step(2); chk("c_done", 32'(bus.lsb_done), 32'd1);
    chk("c_rdata", bus.lsb_rdata, 32'h0000_005E);
    bus.lsb_req = 1'b0;
    step(1);

    // IO word store with back-pressure on cycles 2-4
    lsb_set(1'b0, 2'd2, 32'h0003_0000, 32'h11223344);
    step(1); chk("io_a1", bus.mem_a, 32'h0003_0000); chk("io_d1", 32'(bus.mem_dout), 32'h44);
    bus.io_buffer_full = 1'b1;
    step(1); chk("io_hold", 32'(bus.mem_wr), 32'd0);
    step(2); bus.io_buffer_full = 1'b0;
    step(1); chk("io_a5", bus.mem_a, 32'h0003_0001); chk("io_d5", 32'(bus.mem_dout), 32'h33);
    step(2); chk("io_a7", bus.mem_a, 32'h0003_0003); chk("io_d7", 32'(bus.mem_dout), 32'h11);
    step(1); chk("io_done", 32'(bus.lsb_done), 32'd1);
    bus.lsb_req = 1'b0;
    step(1);

    // pause during a byte store
    lsb_set(1'b0, 2'd0, 32'h40, 32'h0000_005A);
    step(1); rdy_in = 1'b0; #1 chk("p_wr_off", 32'(bus.mem_wr), 32'd0);
    step(1); rdy_in = 1'b1; #1 chk("p_wr_on", 32'(bus.mem_wr), 32'd1);
    chk("p_a", bus.mem_a, 32'h40);
    step(1); chk("p_done", 32'(bus.lsb_done), 32'd1);
    bus.lsb_req = 1'b0;
    step(1);

    // reset in the middle of a word load
    lsb_set(1'b1, 2'd2, 32'h120, 32'h0);
    step(3); rst_in = 1'b0;
    step(1); chk("r_a", bus.mem_a, 32'h0); chk("r_rdata", bus.lsb_rdata, 32'h0);
    chk("r_done", 32'(bus.lsb_done), 32'd0);
    rst_in = 1'b1; bus.lsb_req = 1'b0; bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step(6); chk("r_if_done", 32'(bus.if_done), 32'd1);
    chk("r_if_data", bus.if_data, 32'h0000_0513);
    bus.if_req = 1'b0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
